// File: rtl/connect_arb_pkg.sv
// Shared types and width helpers for the multi-channel request/indication connector.
package connect_arb_pkg;

    localparam int unsigned ENTRY_W = 32;

    typedef struct packed {
        logic [ENTRY_W-1:0] meth;
        logic [ENTRY_W-1:0] v;
    } entry_t;

    // ceil(log2(n)), never less than 1 so single-entry ranges still get a bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/connect_chan_fifo.sv
// Per-channel DEPTH-entry FIFO holding {meth, v}; no write-through when full.
module connect_chan_fifo
    import connect_arb_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = clog2_min1(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enq_i,
    input  logic [2*W-1:0]  data_i,
    input  logic            deq_i,
    output logic            empty_o,
    output logic [2*W-1:0]  head_o,
    output logic [CW-1:0]   count_o
);

    logic [2*W-1:0] mem_q [DEPTH];
    logic [PW-1:0]  rd_q, wr_q;
    logic [CW-1:0]  cnt_q;
    logic           do_enq_c, do_deq_c;

    // Fullness is judged on the pre-edge count, so a pop cannot make room this cycle
    assign do_enq_c = enq_i && (cnt_q != CW'(DEPTH));
    assign do_deq_c = deq_i && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_enq_c) wr_q <= wr_q + PW'(1);
            if (do_deq_c) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_enq_c) - CW'(do_deq_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_enq_c) mem_q[wr_q] <= data_i;
    end

    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/connect_arb_fifo.sv
// CH buffered request channels merged round-robin onto one indication port.
module connect_arb_fifo
    import connect_arb_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CH    = 2,
    localparam int unsigned CHW  = clog2_min1(CH)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CH-1:0]   say__ENA,
    input  logic [CH*W-1:0] say_meth,
    input  logic [CH*W-1:0] say_v,
    output logic [CH-1:0]   say__RDY,
    output logic            ind_heard__ENA,
    output logic [W-1:0]    ind_heard_heard_meth,
    output logic [W-1:0]    ind_heard_heard_v,
    output logic [CHW-1:0]  ind_heard_heard_chan,
    input  logic            ind_heard__RDY,
    input  logic            rule_enable,
    output logic            rule_ready,
    output logic [31:0]     heard_count
);

    localparam int unsigned PW = clog2_min1(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CH-1:0]  nonempty_c, deq_c;
    logic [CW-1:0]  cnt   [CH];
    logic [2*W-1:0] head  [CH];
    logic [CH-1:0]  empty;
    logic [CHW-1:0] last_grant_q, last_grant_d, grant_c;
    logic [31:0]    heard_count_q, heard_count_d;
    logic           any_ne_c, respond_rdy_c, fire_c;
    logic [2*W-1:0] head_sel_c;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        connect_chan_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (CLK),
            .rst_ni  (nRST),
            .enq_i   (say__ENA[c]),
            .data_i  ({say_meth[c*W +: W], say_v[c*W +: W]}),
            .deq_i   (deq_c[c]),
            .empty_o (empty[c]),
            .head_o  (head[c]),
            .count_o (cnt[c])
        );
        assign say__RDY[c]   = (cnt[c] != CW'(DEPTH));
        assign nonempty_c[c] = !empty[c];
        assign deq_c[c]      = fire_c && (grant_c == CHW'(c));
    end

    // First non-empty channel after the last winner, wrapping mod CH
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= CH; i++) begin
            idx = (32'(last_grant_q) + i) % CH;
            if (!found && nonempty_c[CHW'(idx)]) begin
                grant_c = CHW'(idx);
                found   = 1'b1;
            end
        end
    end

    assign any_ne_c      = |nonempty_c;
    assign respond_rdy_c = any_ne_c && ind_heard__RDY;
    assign fire_c        = rule_enable && respond_rdy_c;
    assign head_sel_c    = any_ne_c ? head[grant_c] : '0;

    always_comb begin
        last_grant_d  = last_grant_q;
        heard_count_d = heard_count_q;
        if (fire_c) begin
            last_grant_d  = grant_c;
            heard_count_d = heard_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_grant_q  <= CHW'(CH - 1);
            heard_count_q <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            heard_count_q <= heard_count_d;
        end
    end

    assign rule_ready           = respond_rdy_c;
    assign ind_heard__ENA       = fire_c;
    assign ind_heard_heard_meth = head_sel_c[2*W-1:W];
    assign ind_heard_heard_v    = head_sel_c[W-1:0];
    assign ind_heard_heard_chan = any_ne_c ? grant_c : '0;
    assign heard_count          = heard_count_q;

endmodule

// File: tb/tb_connect_arb_fifo.sv
// Scoreboard bench: per-channel expected queues filled on accepted say, drained on indication.
module tb_connect_arb_fifo;
    import connect_arb_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CH    = 2;
    localparam int unsigned CHW   = 1;

    logic            CLK;
    logic            nRST;
    logic [CH-1:0]   say_ena;
    logic [CH*W-1:0] say_meth, say_v;
    logic [CH-1:0]   say_rdy;
    logic            ind_ena;
    logic [W-1:0]    ind_meth, ind_v;
    logic [CHW-1:0]  ind_chan;
    logic            ind_rdy;
    logic            rule_en;
    logic            rule_rdy;
    logic [31:0]     hc;

    connect_arb_fifo #(.W(W), .DEPTH(DEPTH), .CH(CH)) dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .say__ENA             (say_ena),
        .say_meth             (say_meth),
        .say_v                (say_v),
        .say__RDY             (say_rdy),
        .ind_heard__ENA       (ind_ena),
        .ind_heard_heard_meth (ind_meth),
        .ind_heard_heard_v    (ind_v),
        .ind_heard_heard_chan (ind_chan),
        .ind_heard__RDY       (ind_rdy),
        .rule_enable          (rule_en),
        .rule_ready           (rule_rdy),
        .heard_count          (hc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ind = 0;
    entry_t      mq [CH][$];
    int          mlast = CH - 1;
    int unsigned mhc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int idx;
        for (int i = 1; i <= CH; i++) begin
            idx = (mlast + i) % CH;
            if (mq[idx].size() > 0) return idx;
        end
        return 0;
    endfunction

    task automatic say(input int c, input logic [W-1:0] m, input logic [W-1:0] v);
        say_ena[c]         = 1'b1;
        say_meth[c*W +: W] = m;
        say_v[c*W +: W]    = v;
    endtask

    // Compare outputs mid-cycle against the model, then advance model and DUT by one edge
    task automatic tick();
        logic [CH-1:0] rdy_m;
        bit            ane, fire;
        int            g;
        entry_t        e;
        @(negedge CLK);
        if (!nRST) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            mlast = CH - 1;
            mhc   = 0;
        end else begin
            ane = 1'b0;
            for (int c = 0; c < CH; c++) begin
                rdy_m[c] = (mq[c].size() < DEPTH);
                if (mq[c].size() > 0) ane = 1'b1;
            end
            fire = ane && ind_rdy && rule_en;
            check("say_rdy", 64'(say_rdy), 64'(rdy_m));
            check("rule_ready", 64'(rule_rdy), 64'(ane && ind_rdy));
            check("ind_ena", 64'(ind_ena), 64'(fire));
            check("heard_count", 64'(hc), 64'(mhc));
            if (ane) begin
                g = model_grant();
                e = mq[g][0];
                check("chan", 64'(ind_chan), 64'(g));
                check("meth", 64'(ind_meth), 64'(e.meth));
                check("v", 64'(ind_v), 64'(e.v));
                if (fire) begin
                    void'(mq[g].pop_front());
                    mlast = g;
                    mhc++;
                    n_ind++;
                end
            end else begin
                check("idle_chan", 64'(ind_chan), 64'd0);
                check("idle_data", {ind_meth, ind_v}, 64'd0);
            end
            for (int c = 0; c < CH; c++) begin
                if (say_ena[c] && rdy_m[c]) mq[c].push_back({say_meth[c*W +: W], say_v[c*W +: W]});
            end
        end
        @(posedge CLK);
        #1;
        say_ena = '0;
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int c = 0; c < CH; c++) n += mq[c].size();
        return n;
    endfunction

    initial begin
        int base, budget;
        nRST = 1'b0; say_ena = '0; say_meth = '0; say_v = '0; ind_rdy = 1'b0; rule_en = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        tick();

        // single entry, one-cycle latency
        ind_rdy = 1'b1; rule_en = 1'b1;
        say(0, 32'd5, 32'h11);
        tick(); tick(); tick();
        check("single_hc", 64'(hc), 64'd1);

        // fill ch1 under backpressure, fifth push dropped
        ind_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            say(1, 32'(i), 32'h100 + 32'(i));
            tick();
        end
        check("fill_rdy1", 64'(say_rdy[1]), 64'd0);
        ind_rdy = 1'b1;
        base = n_ind;
        repeat (6) tick();
        check("fill_count", 64'(n_ind - base), 64'd4);

        // round robin across two loaded channels
        ind_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            say(0, 32'h20 + 32'(i), 32'h200 + 32'(i));
            say(1, 32'h30 + 32'(i), 32'h300 + 32'(i));
            tick();
        end
        ind_rdy = 1'b1;
        repeat (7) tick();

        // full ch0: enq blocked while popping, then enq+deq keeps count steady
        ind_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            say(0, 32'h40 + 32'(i), 32'h400 + 32'(i));
            tick();
        end
        ind_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            say(0, 32'h50 + 32'(i), 32'h500 + 32'(i));
            tick();
        end
        repeat (6) tick();

        // backpressure via rule_enable and via downstream ready
        for (int i = 0; i < 2; i++) begin
            say(0, 32'h60 + 32'(i), 32'h600 + 32'(i));
            say(1, 32'h70 + 32'(i), 32'h700 + 32'(i));
            tick();
        end
        rule_en = 1'b0; ind_rdy = 1'b1;
        repeat (3) tick();
        rule_en = 1'b1; ind_rdy = 1'b0;
        repeat (3) tick();
        ind_rdy = 1'b1;
        repeat (5) tick();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            ind_rdy = ($urandom_range(0, 3) != 0);
            rule_en = ($urandom_range(0, 4) != 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 1) != 0) say(c, 32'($urandom), 32'($urandom));
            end
            tick();
        end

        // reset with entries buffered
        ind_rdy = 1'b0; rule_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            say(i % CH, 32'h80 + 32'(i), 32'h800 + 32'(i));
            tick();
        end
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        check("rst_hc", 64'(hc), 64'd0);
        check("rst_rdy", 64'(say_rdy), 64'(2'b11));
        check("rst_rule_ready", 64'(rule_rdy), 64'd0);

        // post-reset traffic then bounded drain
        say(1, 32'h91, 32'h901);
        say(0, 32'h90, 32'h900);
        tick();
        ind_rdy = 1'b1;
        budget = 0;
        while (pending() > 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("drain_left", 64'(pending()), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
